// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: issues data-cache requests for loads/stores,
// stalls until the cache completes, and registers the writeback-stage values.
module mem_access_stage #(
    parameter int DATA_WIDTH          = 32,
    parameter int ADDRESS_WIDTH       = 32,
    parameter int REG_FILE_ADDR_WIDTH = 5
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           regwritem,
    input  logic [2:0]                     resultsrcm,
    input  logic                           memwritem,
    input  logic [2:0]                     funct3m,
    input  logic [DATA_WIDTH-1:0]          aluresultm,
    input  logic [DATA_WIDTH-1:0]          writedatam,
    input  logic [DATA_WIDTH-1:0]          immextm,
    input  logic [ADDRESS_WIDTH-1:0]       pcplus4m,
    input  logic [ADDRESS_WIDTH-1:0]       pctargetm,
    input  logic [REG_FILE_ADDR_WIDTH-1:0] rdm,
    output logic                           mem_req,
    output logic                           mem_we,
    output logic [ADDRESS_WIDTH-1:0]       mem_addr,
    output logic [DATA_WIDTH-1:0]          mem_wdata,
    output logic [3:0]                     mem_wstrb,
    input  logic                           mem_ready,
    input  logic [DATA_WIDTH-1:0]          mem_rdata,
    output logic                           stallm,
    output logic                           regwritew,
    output logic [2:0]                     resultsrcw,
    output logic [DATA_WIDTH-1:0]          aluresultw,
    output logic [DATA_WIDTH-1:0]          readdataw,
    output logic [REG_FILE_ADDR_WIDTH-1:0] rdw,
    output logic [ADDRESS_WIDTH-1:0]       pcplus4w,
    output logic [DATA_WIDTH-1:0]          immextw,
    output logic [ADDRESS_WIDTH-1:0]       pctargetw,
    output logic                           misalignedw,
    output logic [15:0]                    stall_cnt
);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t state_q, state_d;

    logic                           regwritew_q;
    logic [2:0]                     resultsrcw_q;
    logic [DATA_WIDTH-1:0]          aluresultw_q;
    logic [DATA_WIDTH-1:0]          readdataw_q;
    logic [REG_FILE_ADDR_WIDTH-1:0] rdw_q;
    logic [ADDRESS_WIDTH-1:0]       pcplus4w_q;
    logic [DATA_WIDTH-1:0]          immextw_q;
    logic [ADDRESS_WIDTH-1:0]       pctargetw_q;
    logic                           misalignedw_q;
    logic [15:0]                    stall_cnt_q;

    logic       is_load;
    logic       is_store;
    logic       is_access;
    logic       unsupported;
    logic       misaligned;
    logic       acc_ok;
    logic       stall;
    logic [1:0] off;

    function automatic logic [3:0] store_strobe(input logic [1:0] sz, input logic [1:0] bo);
        logic [3:0] s;
        case (sz)
            2'b00:   s = 4'b0001 << bo;
            2'b01:   s = 4'b0011 << {bo[1], 1'b0};
            default: s = 4'b1111;
        endcase
        return s;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] store_format(input logic [1:0] sz,
                                                           input logic [DATA_WIDTH-1:0] wd);
        logic [DATA_WIDTH-1:0] d;
        case (sz)
            2'b00:   d = {(DATA_WIDTH/8){wd[7:0]}};
            2'b01:   d = {(DATA_WIDTH/16){wd[15:0]}};
            default: d = wd;
        endcase
        return d;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] load_extract(input logic [2:0] f3,
                                                           input logic [1:0] bo,
                                                           input logic [DATA_WIDTH-1:0] rd);
        logic [7:0]            b;
        logic [15:0]           h;
        logic [DATA_WIDTH-1:0] v;
        b = 8'(rd >> {bo, 3'b000});
        h = 16'(rd >> {bo[1], 4'b0000});
        case (f3)
            3'b000:  v = {{(DATA_WIDTH-8){b[7]}}, b};
            3'b001:  v = {{(DATA_WIDTH-16){h[15]}}, h};
            3'b100:  v = {{(DATA_WIDTH-8){1'b0}}, b};
            3'b101:  v = {{(DATA_WIDTH-16){1'b0}}, h};
            default: v = rd;
        endcase
        return v;
    endfunction

    // Access decode and alignment check
    assign off = aluresultm[1:0];

    always_comb begin
        is_load     = (resultsrcm == 3'b001);
        is_store    = memwritem;
        is_access   = is_load | is_store;
        unsupported = (funct3m == 3'b011) | (funct3m == 3'b110) | (funct3m == 3'b111);
        misaligned  = is_access & (unsupported
                                   | ((funct3m[1:0] == 2'b01) & off[0])
                                   | ((funct3m[1:0] == 2'b10) & (off != 2'b00)));
        acc_ok      = is_access & ~misaligned;
    end

    // Request and stall are gated by rst_n so a reset drops them immediately,
    // even mid-transaction. The EX/MEM register is frozen while stalled, so the
    // request fields stay stable for the whole wait.
    assign stall     = acc_ok & ~mem_ready & rst_n;
    assign stallm    = stall;
    assign mem_req   = acc_ok & rst_n;
    assign mem_we    = memwritem;
    assign mem_addr  = {aluresultm[ADDRESS_WIDTH-1:2], 2'b00};
    assign mem_wdata = store_format(funct3m[1:0], writedatam);
    assign mem_wstrb = is_store ? store_strobe(funct3m[1:0], off) : 4'b0000;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (acc_ok && !mem_ready) state_d = WAIT;
            WAIT:    if (!acc_ok || mem_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Writeback-stage register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regwritew_q   <= 1'b0;
            resultsrcw_q  <= 3'b000;
            aluresultw_q  <= '0;
            readdataw_q   <= '0;
            rdw_q         <= '0;
            pcplus4w_q    <= '0;
            immextw_q     <= '0;
            pctargetw_q   <= '0;
            misalignedw_q <= 1'b0;
            stall_cnt_q   <= 16'h0000;
        end else if (stall) begin
            regwritew_q   <= 1'b0;
            resultsrcw_q  <= 3'b000;
            misalignedw_q <= 1'b0;
            if (stall_cnt_q != 16'hFFFF) begin
                stall_cnt_q <= stall_cnt_q + 16'h0001;
            end
        end else begin
            regwritew_q   <= regwritem & ~misaligned;
            resultsrcw_q  <= resultsrcm;
            aluresultw_q  <= aluresultm;
            readdataw_q   <= (is_load & ~misaligned) ? load_extract(funct3m, off, mem_rdata) : '0;
            rdw_q         <= rdm;
            pcplus4w_q    <= pcplus4m;
            immextw_q     <= immextm;
            pctargetw_q   <= pctargetm;
            misalignedw_q <= misaligned;
        end
    end

    assign regwritew   = regwritew_q;
    assign resultsrcw  = resultsrcw_q;
    assign aluresultw  = aluresultw_q;
    assign readdataw   = readdataw_q;
    assign rdw         = rdw_q;
    assign pcplus4w    = pcplus4w_q;
    assign immextw     = immextw_q;
    assign pctargetw   = pctargetw_q;
    assign misalignedw = misalignedw_q;
    assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized bench for mem_access_stage against a size/offset-arithmetic
// reference model, plus directed load/store/misalign/reset scenarios.
`timescale 1ns/1ps
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        regwritem, memwritem;
    logic [2:0]  resultsrcm, funct3m;
    logic [31:0] aluresultm, writedatam, immextm, pcplus4m, pctargetm;
    logic [4:0]  rdm;
    logic        mem_req, mem_we, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    logic        stallm, regwritew, misalignedw;
    logic [2:0]  resultsrcw;
    logic [31:0] aluresultw, readdataw, pcplus4w, immextw, pctargetw;
    logic [4:0]  rdw;
    logic [15:0] stall_cnt;

    always #5 clk = ~clk;

    mem_access_stage dut (
        .clk(clk), .rst_n(rst_n),
        .regwritem(regwritem), .resultsrcm(resultsrcm), .memwritem(memwritem), .funct3m(funct3m),
        .aluresultm(aluresultm), .writedatam(writedatam), .immextm(immextm),
        .pcplus4m(pcplus4m), .pctargetm(pctargetm), .rdm(rdm),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .stallm(stallm), .regwritew(regwritew), .resultsrcw(resultsrcw),
        .aluresultw(aluresultw), .readdataw(readdataw), .rdw(rdw), .pcplus4w(pcplus4w),
        .immextw(immextw), .pctargetw(pctargetw), .misalignedw(misalignedw),
        .stall_cnt(stall_cnt)
    );

    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: expected combinational response and writeback state
    logic        e_load, e_store, e_acc, e_mis, e_ok, e_stall;
    logic [31:0] e_addr, e_wdata, e_lval;
    logic [3:0]  e_strb;
    logic        m_regwrite, m_mis;
    logic [2:0]  m_resultsrc;
    logic [31:0] m_alu, m_read, m_pc4, m_imm, m_pct;
    logic [4:0]  m_rd;
    int          m_cnt;

    task automatic model_reset();
        m_regwrite = 0; m_mis = 0; m_resultsrc = 0; m_alu = 0; m_read = 0;
        m_pc4 = 0; m_imm = 0; m_pct = 0; m_rd = 0; m_cnt = 0;
    endtask

    task automatic model_comb();
        int          size, off;
        logic [31:0] mask, v;
        e_load  = (resultsrcm == 3'd1);
        e_store = memwritem;
        e_acc   = e_load || e_store;
        off     = int'(aluresultm[1:0]);
        case (funct3m)
            3'd0, 3'd4: size = 1;
            3'd1, 3'd5: size = 2;
            3'd2:       size = 4;
            default:    size = 0;
        endcase
        e_mis   = e_acc && (size == 0 || (off % size) != 0);
        e_ok    = e_acc && !e_mis;
        e_stall = e_ok && !mem_ready;
        e_addr  = aluresultm - 32'(off);
        mask    = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
        e_strb  = 4'(((1 << size) - 1) << off);
        e_wdata = (size == 1) ? (writedatam & 32'hFF) * 32'h0101_0101 :
                  (size == 2) ? (writedatam & 32'hFFFF) * 32'h0001_0001 : writedatam;
        v = (mem_rdata >> (8 * off)) & mask;
        if (!funct3m[2] && size > 0 && size < 4 && v[8 * size - 1]) v = v | ~mask;
        e_lval = v;
    endtask

    task automatic model_seq();
        if (e_stall) begin
            m_regwrite = 0; m_resultsrc = 0; m_mis = 0;
            if (m_cnt < 65535) m_cnt++;
        end else begin
            m_regwrite  = regwritem && !e_mis;
            m_resultsrc = resultsrcm;
            m_alu       = aluresultm;
            m_read      = (e_load && !e_mis) ? e_lval : 32'd0;
            m_rd        = rdm;
            m_pc4       = pcplus4m;
            m_imm       = immextm;
            m_pct       = pctargetm;
            m_mis       = e_mis;
        end
    endtask

    task automatic check_w();
        check_val("regwritew", regwritew, m_regwrite);
        check_val("resultsrcw", resultsrcw, m_resultsrc);
        check_val("aluresultw", aluresultw, m_alu);
        check_val("readdataw", readdataw, m_read);
        check_val("rdw", rdw, m_rd);
        check_val("pcplus4w", pcplus4w, m_pc4);
        check_val("immextw", immextw, m_imm);
        check_val("pctargetw", pctargetw, m_pct);
        check_val("misalignedw", misalignedw, m_mis);
        check_val("stall_cnt", stall_cnt, 32'(m_cnt));
    endtask

    // Entered at posedge+1 with inputs applied; returns at the next posedge+1.
    task automatic cycle(output logic stalled);
        #4;
        model_comb();
        check_val("mem_req", mem_req, e_ok);
        check_val("stallm", stallm, e_stall);
        if (e_ok) begin
            check_val("mem_addr", mem_addr, e_addr);
            check_val("mem_we", mem_we, e_store);
            if (e_store) begin
                check_val("mem_wstrb", mem_wstrb, e_strb);
                check_val("mem_wdata", mem_wdata, e_wdata);
            end
        end
        stalled = e_stall;
        @(posedge clk);
        model_seq();
        #1;
        check_w();
    endtask

    task automatic set_in(input logic rw, input logic [2:0] rs, input logic mw,
                          input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] wd);
        regwritem = rw; resultsrcm = rs; memwritem = mw; funct3m = f3;
        aluresultm = alu; writedatam = wd;
        immextm = $urandom; pcplus4m = $urandom; pctargetm = $urandom; rdm = 5'($urandom);
    endtask

    task automatic run_instr(input int lat, input logic [31:0] rdata);
        int   n;
        logic st;
        n = 0;
        forever begin
            mem_ready = (n >= lat);
            mem_rdata = (n >= lat) ? rdata : $urandom;
            cycle(st);
            if (!st) break;
            n++;
            if (n > 40) begin
                check_val("ready_timeout", 32'd1, 32'd0);
                break;
            end
        end
    endtask

    initial begin
        logic st;
        logic [15:0] cnt_before;
        logic [2:0]  sf3 [6];
        sf3 = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd6, 3'd7};

        rst_n = 0; mem_ready = 0; mem_rdata = 0;
        set_in(0, 3'd0, 0, 3'd0, 32'd0, 32'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_w();
        check_val("reset_mem_req", mem_req, 0);
        check_val("reset_stallm", stallm, 0);
        rst_n = 1;

        // LW with same-cycle ready
        set_in(1, 3'd1, 0, 3'd2, 32'h100, 32'h0);
        run_instr(0, 32'hDEAD_BEEF);
        check_val("lw_read", readdataw, 32'hDEAD_BEEF);
        check_val("lw_regw", regwritew, 1);

        // LB with three wait cycles
        set_in(1, 3'd1, 0, 3'd0, 32'h103, 32'h0);
        run_instr(3, 32'h80FF_0000);
        check_val("lb_read", readdataw, 32'hFFFF_FF80);
        check_val("lb_cnt", stall_cnt, 32'd3);

        // SH to upper halfword
        set_in(1, 3'd0, 1, 3'd1, 32'h202, 32'h1234_ABCD);
        run_instr(0, $urandom);
        check_val("sh_strb", mem_wstrb, 4'b1100);
        check_val("sh_wdata", mem_wdata, 32'hABCD_ABCD);
        check_val("sh_addr", mem_addr, 32'h200);
        check_val("sh_regw", regwritew, 1);

        // Misaligned LW
        set_in(1, 3'd1, 0, 3'd2, 32'h101, 32'h0);
        run_instr(0, $urandom);
        check_val("mis_flag", misalignedw, 1);
        check_val("mis_regw", regwritew, 0);
        check_val("mis_req", mem_req, 0);
        set_in(1, 3'd0, 0, 3'd0, $urandom, 32'h0);
        run_instr(0, $urandom);
        check_val("mis_pulse_end", misalignedw, 0);

        // Back-to-back ALU ops
        cnt_before = stall_cnt;
        for (int i = 0; i < 4; i++) begin
            set_in(1'($urandom), 3'd0, 0, 3'($urandom), $urandom, $urandom);
            run_instr(int'($urandom_range(0, 1)), $urandom);
        end
        check_val("alu_cnt", stall_cnt, 32'(cnt_before));

        // Reset during the second WAIT cycle
        set_in(1, 3'd1, 0, 3'd2, 32'h300, 32'h0);
        mem_ready = 0;
        cycle(st);
        cycle(st);
        #2;
        rst_n = 0;
        #1;
        check_val("rstw_req", mem_req, 0);
        check_val("rstw_stall", stallm, 0);
        check_val("rstw_regw", regwritew, 0);
        check_val("rstw_cnt", stall_cnt, 0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1;
        run_instr(0, 32'hCAFE_F00D);
        check_val("post_rst_read", readdataw, 32'hCAFE_F00D);

        // Randomized mix
        for (int i = 0; i < 300; i++) begin
            int kind;
            logic [31:0] a;
            kind = int'($urandom_range(0, 2));
            a = $urandom;
            if (kind == 0)
                set_in(1'($urandom), 3'($urandom_range(0, 4)) & 3'b110, 0, 3'($urandom), a, $urandom);
            else if (kind == 1)
                set_in(1'($urandom), 3'd1, 0, 3'($urandom), a, $urandom);
            else
                set_in(1'($urandom), 3'($urandom_range(0, 4)) & 3'b110, 1,
                       sf3[$urandom_range(0, 5)], a, $urandom);
            run_instr(int'($urandom_range(0, 3)), $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, 32, data word width; ADDRESS_WIDTH, 32, byte address width; REG_FILE_ADDR_WIDTH, 5, register index width.
REQ-002 clk  in  1  single clock; all state updates on posedge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 regwritem, resultsrcm[2:0], memwritem, funct3m[2:0]  in  control from the execute/memory pipeline register.
REQ-005 aluresultm, writedatam, immextm  in  DATA_WIDTH; pcplus4m, pctargetm  in  ADDRESS_WIDTH; rdm  in  REG_FILE_ADDR_WIDTH.
REQ-006 mem_req  out  1; mem_we  out  1; mem_addr  out  ADDRESS_WIDTH (word-aligned); mem_wdata  out  DATA_WIDTH; mem_wstrb  out  4 -- data cache request.
REQ-007 mem_ready  in  1; mem_rdata  in  DATA_WIDTH -- cache completion and read word.
REQ-008 stallm  out  1  freezes PC, fetch/decode/execute registers and the execute/memory register.
REQ-009 regwritew, resultsrcw[2:0], aluresultw, readdataw, rdw, pcplus4w, immextw, pctargetw  out  registered writeback-stage values.
REQ-010 misalignedw  out  1  registered one-cycle error pulse; stall_cnt  out  16  saturating stall-cycle counter.

Function
REQ-011 Load SHALL mean resultsrcm==3'b001; store SHALL mean memwritem==1; access = load or store.
REQ-012 Misaligned SHALL mean halfword (funct3[1:0]==01) with addr[0]==1, or word (funct3[1:0]==10) with addr[1:0]!=0; misaligned accesses SHALL NOT assert mem_req.
REQ-013 FSM states SHALL be IDLE and WAIT; reset state IDLE.
REQ-014 IDLE: aligned access -> mem_req=1 combinationally; mem_ready=1 same cycle -> complete, stay IDLE; else -> WAIT.
REQ-015 WAIT: mem_req held 1 with unchanged addr/we/wdata/wstrb; mem_ready=1 -> complete, go IDLE.
REQ-016 stallm SHALL equal (aligned access) AND NOT mem_ready, in both states.
REQ-017 mem_addr SHALL be aluresultm with bits [1:0] cleared; mem_we=memwritem.
REQ-018 Store strobes: SB 4'b0001<<addr[1:0]; SH 4'b0011<<(2*addr[1]); SW 4'b1111; mem_wdata = byte replicated x4 (SB), halfword x2 (SH), word (SW).
REQ-019 Load data from mem_rdata: LB/LBU select byte addr[1:0], LH/LHU halfword addr[1], sign-extend for funct3 000/001, zero-extend for 100/101, LW full word.
REQ-020 Unsupported funct3 on an access (011, 110, 111) SHALL be treated as misaligned.
REQ-021 Writeback register SHALL capture all M inputs and extracted load data on every posedge with stallm==0; readdataw undefined-but-stable for non-loads (hold 0).
REQ-022 Cycle with stallm==1 SHALL load a bubble: regwritew=0, resultsrcw=0, other W fields hold.
REQ-023 Misaligned or unsupported access: no stall, regwritew=0, misalignedw=1 for exactly the next cycle.
REQ-024 Non-access instructions SHALL pass through with one-cycle latency, no stall.
REQ-025 stall_cnt SHALL increment each cycle stallm==1, saturating at 16'hFFFF.
REQ-026 mem_ready while mem_req==0 SHALL be ignored.

Reset
REQ-027 rst_n low SHALL immediately force IDLE, mem_req=0, stallm=0, all W outputs 0, misalignedw=0, stall_cnt=0.
REQ-028 Reset during WAIT SHALL abandon the request; mem_req low asynchronously; no writeback of the pending load.
REQ-029 First access after rst_n release SHALL be accepted on the first posedge.

Verification
REQ-030 LW addr 0x100, mem_ready=1 same cycle, mem_rdata 0xDEADBEEF -> no stall, next cycle readdataw 0xDEADBEEF, regwritew=1.
REQ-031 LB addr 0x103, mem_rdata 0x80FF_0000, ready after 3 cycles -> stallm high 3 cycles, 3 bubbles, readdataw 0xFFFFFF80, stall_cnt=3.
REQ-032 SH addr 0x202 data 0x1234ABCD -> mem_wstrb 4'b1100, mem_wdata 0xABCDABCD, mem_addr 0x200, regwritew follows regwritem.
REQ-033 LW addr 0x101 -> mem_req=0, stallm=0, next cycle misalignedw=1, regwritew=0.
REQ-034 Reset asserted in WAIT cycle 2 -> mem_req, stallm, regwritew, stall_cnt 0 immediately; IDLE after release.
REQ-035 ALU op (no access) back-to-back x4 -> no stall, each W value appears one cycle later; stall_cnt unchanged.
